// File: rtl/digi_ota_cal_seq.sv
// Offset-calibration sequencer for the inverter-based digital OTA/comparator.
// Successive-approximation search on the trim code, each bit decided by a majority vote over averaged samples.
module digi_ota_cal_seq #(
  parameter int TRIM_W     = 5,
  parameter int SETTLE_CYC = 4,
  parameter int AVG_LOG2   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cmp_in,
  output logic              ota_en,
  output logic              cal_mode,
  output logic [TRIM_W-1:0] trim,
  output logic              busy,
  output logic              done,
  output logic              cal_ok
);

  localparam int N       = 1 << AVG_LOG2;
  localparam int CNT_MAX = (SETTLE_CYC > N) ? SETTLE_CYC : N;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = $clog2(TRIM_W);
  localparam int ONES_W  = AVG_LOG2 + 1;

  localparam logic [TRIM_W-1:0] MID = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]  TOP = IDX_W'(TRIM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_SAMPLE, S_DECIDE, S_FINISH, S_RUN
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_sync;
  logic [TRIM_W-1:0]   r_trim;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [ONES_W-1:0]   r_ones;
  logic                r_cal_ok;

  logic                w_cmp_s;
  logic                w_settle_last;
  logic                w_sample_last;
  logic                w_ones_hi;
  logic                w_idx_zero;
  logic [IDX_W-1:0]    w_idx_dn;

  assign w_cmp_s       = r_sync[1];
  assign w_settle_last = (r_cnt == CNT_W'(SETTLE_CYC - 1));
  assign w_sample_last = (r_cnt == CNT_W'(N - 1));
  assign w_ones_hi     = (r_ones > ONES_W'(N / 2));
  assign w_idx_zero    = (r_idx == '0);
  assign w_idx_dn      = r_idx - IDX_W'(1);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin : p_state
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin : p_next
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN: if (start) w_next = S_SETTLE;
      S_SETTLE: begin
        if (abort)              w_next = S_IDLE;
        else if (w_settle_last) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)              w_next = S_IDLE;
        else if (w_sample_last) w_next = S_DECIDE;
      end
      S_DECIDE: begin
        if (abort)           w_next = S_IDLE;
        else if (w_idx_zero) w_next = S_FINISH;
        else                 w_next = S_SETTLE;
      end
      S_FINISH: w_next = S_RUN;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin : p_out
    ota_en   = 1'b0;
    cal_mode = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_SETTLE, S_SAMPLE, S_DECIDE: begin
        ota_en   = 1'b1;
        cal_mode = 1'b1;
        busy     = 1'b1;
      end
      S_FINISH: begin
        ota_en   = 1'b1;
        cal_mode = 1'b1;
        done     = 1'b1;
      end
      S_RUN:   ota_en = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin : p_data
    if (rst) begin
      r_sync   <= '0;
      r_trim   <= MID;
      r_idx    <= TOP;
      r_cnt    <= '0;
      r_ones   <= '0;
      r_cal_ok <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], cmp_in};
      if (busy && abort) begin
        r_trim   <= MID;
        r_cnt    <= '0;
        r_cal_ok <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_RUN: begin
            if (start) begin
              r_trim   <= MID;
              r_idx    <= TOP;
              r_cnt    <= '0;
              r_cal_ok <= 1'b0;
            end
          end
          S_SETTLE: begin
            if (w_settle_last) begin
              r_cnt  <= '0;
              r_ones <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_SAMPLE: begin
            r_ones <= r_ones + ONES_W'(w_cmp_s);
            r_cnt  <= w_sample_last ? '0 : r_cnt + CNT_W'(1);
          end
          S_DECIDE: begin
            // Majority says the offset is still too high: drop this bit; a tie keeps it.
            if (w_ones_hi) r_trim[r_idx] <= 1'b0;
            if (!w_idx_zero) begin
              r_trim[w_idx_dn] <= 1'b1;
              r_idx            <= w_idx_dn;
            end
            r_cnt <= '0;
          end
          S_FINISH: r_cal_ok <= (r_trim != '0) && (r_trim != '1);
          default: ;
        endcase
      end
    end
  end

  assign trim   = r_trim;
  assign cal_ok = r_cal_ok;

endmodule

// File: tb/tb_digi_ota_cal_seq.sv
// Self-checking bench for digi_ota_cal_seq: per-cycle comparison against a timeline/SAR model,
// plus directed runs with hand-computed trial sequences, latencies and final codes.
module tb_digi_ota_cal_seq;

  localparam int TW   = 5;
  localparam int SC   = 4;
  localparam int AV   = 3;
  localparam int N    = 1 << AV;
  localparam int BITC = SC + N + 1;
  localparam int LAT  = TW * BITC + 1;
  localparam int THR  = 13;
  localparam logic [TW-1:0] MID = 5'b10000;

  logic          clk = 1'b0;
  logic          rst, start, abort, cmp_in;
  logic          ota_en, cal_mode, busy, done, cal_ok;
  logic [TW-1:0] trim;

  int   mode = 1;
  logic r_tog = 1'b0;
  bit   chk_en = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  logic [TW-1:0] cap [TW];
  logic [TW-1:0] seq_zero [TW] = '{5'd16, 5'd24, 5'd28, 5'd30, 5'd31};
  logic [TW-1:0] seq_thr  [TW] = '{5'd16, 5'd8,  5'd12, 5'd14, 5'd13};

  digi_ota_cal_seq #(.TRIM_W(TW), .SETTLE_CYC(SC), .AVG_LOG2(AV)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .cmp_in   (cmp_in),
    .ota_en   (ota_en),
    .cal_mode (cal_mode),
    .trim     (trim),
    .busy     (busy),
    .done     (done),
    .cal_ok   (cal_ok)
  );

  always #5 clk = ~clk;
  always @(negedge clk) r_tog = ~r_tog;

  // Comparator stimulus: 0 = stuck low, 1 = stuck high, 2 = OTA with offset (trip above THR), 3 = toggling.
  assign cmp_in = (mode == 0) ? 1'b0 :
                  (mode == 1) ? 1'b1 :
                  (mode == 2) ? (int'(trim) > THR) : r_tog;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Ones counted in a window of N samples for a given trial code.
  function automatic int f_ones(input int md, input logic [TW-1:0] code);
    case (md)
      0:       return 0;
      1:       return N;
      2:       return (int'(code) > THR) ? N : 0;
      default: return N / 2;
    endcase
  endfunction

  // Model: cycle position within a calibration plus the trial codes a SAR search visits.
  bit            m_cal = 1'b0;
  bit            m_en  = 1'b0;
  bit            m_ok  = 1'b0;
  int            m_cyc = 0;
  logic [TW-1:0] m_trim = MID;
  logic [TW-1:0] m_final = MID;
  logic [TW-1:0] m_tr [TW];

  always @(posedge clk) begin
    if (rst) begin
      m_cal  = 1'b0;
      m_en   = 1'b0;
      m_ok   = 1'b0;
      m_cyc  = 0;
      m_trim = MID;
    end else if (m_cal) begin
      if (abort && m_cyc < LAT) begin
        m_cal  = 1'b0;
        m_en   = 1'b0;
        m_ok   = 1'b0;
        m_trim = MID;
      end else if (m_cyc == LAT) begin
        m_cal  = 1'b0;
        m_trim = m_final;
        m_ok   = (m_final != '0) && (m_final != '1);
      end else begin
        m_cyc++;
      end
    end else if (start) begin
      logic [TW-1:0] code;
      m_cal = 1'b1;
      m_cyc = 1;
      m_en  = 1'b1;
      m_ok  = 1'b0;
      code  = MID;
      for (int j = TW - 1; j >= 0; j--) begin
        m_tr[TW-1-j] = code;
        if (f_ones(mode, code) > N / 2) code[j] = 1'b0;
        if (j > 0) code[j-1] = 1'b1;
      end
      m_final = code;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [TW-1:0] exp_trim;
      if (m_cal) exp_trim = (m_cyc < LAT) ? m_tr[(m_cyc-1)/BITC] : m_final;
      else       exp_trim = m_trim;
      check("busy",   busy,   m_cal && m_cyc < LAT);
      check("done",   done,   m_cal && m_cyc == LAT);
      check("ota_en", ota_en, m_en);
      if (!(m_cal && m_cyc == LAT)) check("cal_mode", cal_mode, m_cal);
      check("trim",   trim,   exp_trim);
      check("cal_ok", cal_ok, m_cal ? 1'b0 : m_ok);
    end
  end

  // Pulses start (optionally with abort), then waits for done with a bounded cycle budget.
  // lat is the cycle done was seen, counting the start cycle as 0; 150 means it never came.
  task automatic run_cal(input bit ab_with_start, input int s2_at, input int ab_at,
                         input int rs_at, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1;
    abort = ab_with_start;
    @(negedge clk);
    start  = 1'b0;
    abort  = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (done !== 1'b1 && lat < 150) begin
      if ((lat - 1) % BITC == 0 && (lat - 1) / BITC < TW) cap[(lat-1)/BITC] = trim;
      if (busy === 1'b1) busy_n++;
      start = (lat == s2_at);
      abort = (lat == ab_at);
      rst   = (lat == rs_at);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    int lat, busy_n;
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    mode  = 1;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ota_en",   ota_en,   1'b0);
    check("rst_cal_mode", cal_mode, 1'b0);
    check("rst_trim",     trim,     5'b10000);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_cal_ok",   cal_ok,   1'b0);
    rst   = 1'b0;
    start = 1'b0;

    // Stuck-low comparator: every bit kept.
    mode = 0;
    run_cal(1'b0, 0, 0, 0, lat, busy_n);
    check("zero_latency", lat, 66);
    for (int k = 0; k < TW; k++) check("zero_trial", cap[k], seq_zero[k]);
    @(negedge clk);
    check("zero_trim",     trim,     5'b11111);
    check("zero_cal_ok",   cal_ok,   1'b0);
    check("zero_ota_en",   ota_en,   1'b1);
    check("zero_cal_mode", cal_mode, 1'b0);

    // Stuck-high comparator, started from RUN: every bit dropped.
    mode = 1;
    run_cal(1'b0, 0, 0, 0, lat, busy_n);
    check("one_latency", lat, 66);
    @(negedge clk);
    check("one_trim",   trim,   5'b00000);
    check("one_cal_ok", cal_ok, 1'b0);

    // Offset OTA tripping above 13.
    mode = 2;
    run_cal(1'b0, 0, 0, 0, lat, busy_n);
    check("thr_latency",     lat,    66);
    check("thr_busy_cycles", busy_n, 65);
    check("thr_finish_busy", busy,   1'b0);
    for (int k = 0; k < TW; k++) check("thr_trial", cap[k], seq_thr[k]);
    @(negedge clk);
    check("thr_trim",   trim,   5'b01101);
    check("thr_cal_ok", cal_ok, 1'b1);

    // Tie on every bit: 4 of 8 samples high.
    mode = 3;
    run_cal(1'b0, 0, 0, 0, lat, busy_n);
    check("tie_latency", lat, 66);
    @(negedge clk);
    check("tie_trim",   trim,   5'b11111);
    check("tie_cal_ok", cal_ok, 1'b0);

    // Second start mid-calibration is ignored.
    mode = 2;
    run_cal(1'b0, 20, 0, 0, lat, busy_n);
    check("restart_ignored_latency", lat, 66);
    @(negedge clk);
    check("restart_ignored_trim", trim, 5'b01101);

    // Abort in RUN has no effect.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("run_abort_busy",   busy,   1'b0);
    check("run_abort_ota_en", ota_en, 1'b1);
    check("run_abort_trim",   trim,   5'b01101);
    check("run_abort_cal_ok", cal_ok, 1'b1);

    // Abort at cycle 30: back to IDLE, no done.
    run_cal(1'b0, 0, 30, 0, lat, busy_n);
    check("abort_no_done",  lat,      150);
    check("abort_trim",     trim,     5'b10000);
    check("abort_ota_en",   ota_en,   1'b0);
    check("abort_busy",     busy,     1'b0);
    check("abort_cal_mode", cal_mode, 1'b0);
    check("abort_cal_ok",   cal_ok,   1'b0);

    // Start and abort together in IDLE: start wins.
    run_cal(1'b1, 0, 0, 0, lat, busy_n);
    check("start_abort_latency", lat, 66);
    @(negedge clk);
    check("start_abort_trim", trim, 5'b01101);

    // Reset at cycle 40 of a new run.
    mode = 0;
    run_cal(1'b0, 0, 0, 40, lat, busy_n);
    check("rst_mid_no_done",  lat,      150);
    check("rst_mid_trim",     trim,     5'b10000);
    check("rst_mid_ota_en",   ota_en,   1'b0);
    check("rst_mid_cal_mode", cal_mode, 1'b0);
    check("rst_mid_busy",     busy,     1'b0);
    check("rst_mid_cal_ok",   cal_ok,   1'b0);

    // Full recalibration after the reset.
    mode = 2;
    run_cal(1'b0, 0, 0, 0, lat, busy_n);
    check("post_rst_latency", lat, 66);
    @(negedge clk);
    check("post_rst_trim",   trim,   5'b01101);
    check("post_rst_cal_ok", cal_ok, 1'b1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/digi_ota_cal_seq.md
Name: digi_ota_cal_seq

Overview:
Calibration sequencer for the inverter-based digital OTA/comparator. It enables the OTA and shorts its inputs through cal_mode. It then runs a successive-approximation search on a TRIM_W-bit offset-trim code, deciding each bit by majority vote over averaged comparator samples. After calibration it leaves the OTA enabled in run mode with the final trim code held.

Parameters:
TRIM_W, 5, width of offset-trim code (>=2)
SETTLE_CYC, 4, cycles waited after each trim change before sampling (>=2, covers the 2-flop synchronizer)
AVG_LOG2, 3, log2 of comparator samples per bit decision (N = 2^AVG_LOG2 = 8)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  begin calibration; sampled only in IDLE or RUN
abort  input  1  cancel calibration in progress
cmp_in  input  1  raw OTA comparator output (asynchronous to clk)
ota_en  output  1  OTA enable
cal_mode  output  1  1 = OTA inputs shorted for offset measurement
trim  output  TRIM_W  offset-trim code to OTA
busy  output  1  calibration in progress
done  output  1  one-cycle pulse at calibration completion
cal_ok  output  1  final code not railed (not all-0, not all-1)

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values: ota_en=0, cal_mode=0, trim=midscale (1 followed by TRIM_W-1 zeros, i.e. 5'b10000), busy=0, done=0, cal_ok=0, state=IDLE, synchronizer flops=0.
- cmp_in passes through a 2-flop synchronizer (cmp_s). Only cmp_s is used internally.
- States: IDLE, SETTLE, SAMPLE, DECIDE, FINISH, RUN.
- IDLE/RUN + start=1: trim<=midscale, bit index i<=TRIM_W-1, cal_ok<=0, go to SETTLE. busy=1, ota_en=1, cal_mode=1 from the next cycle.
- SETTLE: counts SETTLE_CYC cycles, then goes to SAMPLE.
- SAMPLE: N cycles. Each cycle adds cmp_s to ones counter (width AVG_LOG2+1, cleared on entry). Then goes to DECIDE.
- DECIDE (1 cycle):
  - if ones > N/2, trim[i]<=0; else trim[i] stays 1. A tie (ones == N/2) keeps the bit.
  - if i>0: trim[i-1]<=1, i<=i-1, go to SETTLE.
  - if i==0: go to FINISH.
- FINISH (1 cycle): done=1, cal_ok<=(trim!=0 && trim!=all-ones), go to RUN.
- RUN: ota_en=1, cal_mode=0, busy=0, trim held. A new start recalibrates.
- Latency: done is asserted exactly TRIM_W*(SETTLE_CYC+N+1)+1 cycles after the start cycle. With defaults this is 66.
- start while busy: ignored.
- abort while busy: next cycle goes to IDLE, trim<=midscale, ota_en=0, cal_mode=0, busy=0, cal_ok=0, no done pulse.
  - abort in IDLE/RUN: no effect.
  - abort and start in the same cycle in IDLE/RUN: start wins.
- rst mid-operation: all registers return to reset values next cycle, no done.
- done is never asserted for more than one cycle. busy=0 in the FINISH cycle.

Test Plan:
- Reset: assert rst 2 cycles with start=1, cmp_in=1 -> ota_en=0, cal_mode=0, trim=10000, busy=0, done=0, cal_ok=0.
- cmp_in held 0, pulse start -> trim walks 10000, 11000, 11100, 11110, 11111. done pulses at cycle 66 after start, then trim=11111, cal_ok=0, ota_en=1, cal_mode=0.
- cmp_in held 1 -> final trim=00000, done at cycle 66, cal_ok=0.
- Behavioural OTA model cmp_in=(trim>13) -> trial sequence 16,8,12,14,13, final trim=01101, cal_ok=1, busy high for the whole calibration and low in FINISH.
- Tie: cmp_in toggles every cycle (4 of 8 samples high) -> every bit kept, trim=11111, cal_ok=0.
- Controls during calibration:
  - second start mid-calibration -> ignored, done still at cycle 66.
  - abort at cycle 30 -> trim=10000, ota_en=0, busy=0, no done.
  - rst at cycle 40 of a new run -> reset values.
  - restart from RUN -> full 66-cycle recalibration.
